// File: rtl/toy_cpu_pkg.sv
// Shared encodings for the multi-cycle toy CPU: FSM states, ALU ops, opcodes
// and instruction field positions.
package toy_cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_e;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_SUBI = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_IN   = 4'hA;
   localparam logic [3:0] OP_OUT  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_JZ   = 4'hD;
   localparam logic [3:0] OP_JC   = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int IMM_W   = 8;

endpackage

// File: rtl/toy_alu_flags.sv
// Combinational DATA_W-wide ALU returning result plus C,V,N,Z flags.
module toy_alu_flags
   import toy_cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] res_o,
   output logic              c_o,
   output logic              v_o,
   output logic              n_o,
   output logic              z_o
);

   logic [DATA_W-1:0] b_s;
   logic [DATA_W:0]   sum_s;

   // Subtract is A + ~B + 1, so C=1 means no borrow.
   always_comb begin
      b_s   = (op_i == ALU_SUB) ? ~b_i : b_i;
      sum_s = {1'b0, a_i} + {1'b0, b_s} + {{DATA_W{1'b0}}, (op_i == ALU_SUB)};
      res_o = sum_s[DATA_W-1:0];
      c_o   = sum_s[DATA_W];
      v_o   = (a_i[DATA_W-1] == b_s[DATA_W-1]) && (res_o[DATA_W-1] != a_i[DATA_W-1]);
      case (op_i)
         ALU_AND: begin
            res_o = a_i & b_i;
            c_o   = 1'b0;
            v_o   = 1'b0;
         end
         ALU_OR: begin
            res_o = a_i | b_i;
            c_o   = 1'b0;
            v_o   = 1'b0;
         end
         default: begin
         end
      endcase
      n_o = res_o[DATA_W-1];
      z_o = (res_o == {DATA_W{1'b0}});
   end

endmodule

// File: rtl/toy_cpu_mc.sv
// Multi-cycle toy CPU: FETCH/EXEC FSM, prog-load port, handshaked IN/OUT, HALT.
module toy_cpu_mc
   import toy_cpu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 6,
   parameter int DMEM_AW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_valid,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [15:0]       prog_data,
   output logic              prog_ready,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              halted,
   output logic [PC_W-1:0]   dbg_pc,
   output logic [DATA_W-1:0] dbg_acc
);

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] regs_q [4];
   logic              c_q, v_q, n_q, z_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic [15:0]       imem_q [2**PC_W];
   logic [DATA_W-1:0] dmem_q [2**DMEM_AW];

   logic [3:0]         opc_s;
   logic [1:0]         rd_s, rs_s, alu_op_s;
   logic [DATA_W-1:0]  imm_s, rd_val_s, rs_val_s, alu_b_s, alu_res_s, rf_wdata_s;
   logic               alu_c_s, alu_v_s, alu_n_s, alu_z_s;
   logic               rf_we_s, flag_we_s, dmem_we_s, out_we_s;
   logic [DMEM_AW-1:0] daddr_s;
   logic [PC_W-1:0]    tgt_s;

   // Instruction decode and operand selection.
   always_comb begin
      opc_s    = ir_q[OPC_LSB +: 4];
      rd_s     = ir_q[RD_LSB +: 2];
      rs_s     = ir_q[RS_LSB +: 2];
      daddr_s  = ir_q[DMEM_AW-1:0];
      tgt_s    = ir_q[PC_W-1:0];
      for (int i = 0; i < DATA_W; i++) begin
         imm_s[i] = (i < IMM_W) ? ir_q[i] : 1'b0;
      end
      rd_val_s = regs_q[rd_s];
      rs_val_s = regs_q[rs_s];
      alu_b_s  = (opc_s == OP_ADDI || opc_s == OP_SUBI) ? imm_s : rs_val_s;
      case (opc_s)
         OP_ADD, OP_ADDI: alu_op_s = ALU_ADD;
         OP_SUB, OP_SUBI: alu_op_s = ALU_SUB;
         OP_AND:          alu_op_s = ALU_AND;
         default:         alu_op_s = ALU_OR;
      endcase
   end

   toy_alu_flags #(.DATA_W(DATA_W)) u_alu (
      .op_i (alu_op_s),
      .a_i  (rd_val_s),
      .b_i  (alu_b_s),
      .res_o(alu_res_s),
      .c_o  (alu_c_s),
      .v_o  (alu_v_s),
      .n_o  (alu_n_s),
      .z_o  (alu_z_s)
   );

   // Next-state, PC and write-enable logic; every architectural update lands on the EXEC edge.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      rf_we_s    = 1'b0;
      rf_wdata_s = {DATA_W{1'b0}};
      flag_we_s  = 1'b0;
      dmem_we_s  = 1'b0;
      out_we_s   = 1'b0;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = {PC_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         ST_FETCH: begin
            ir_d    = imem_q[pc_q];
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_q + PC_W'(1);
            case (opc_s)
               OP_LDI: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = imm_s;
               end
               OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_OR: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = alu_res_s;
                  flag_we_s  = 1'b1;
               end
               OP_LD: begin
                  rf_we_s    = 1'b1;
                  rf_wdata_s = dmem_q[daddr_s];
               end
               OP_ST:  dmem_we_s = 1'b1;
               OP_IN: begin
                  if (in_valid) begin
                     rf_we_s    = 1'b1;
                     rf_wdata_s = in_data;
                  end else begin
                     state_d = ST_EXEC;
                     pc_d    = pc_q;
                  end
               end
               OP_OUT: out_we_s = 1'b1;
               OP_JMP: pc_d = tgt_s;
               OP_JZ: begin
                  if (z_q) pc_d = tgt_s;
                  else     pc_d = pc_q + PC_W'(1);
               end
               OP_JC: begin
                  if (c_q) pc_d = tgt_s;
                  else     pc_d = pc_q + PC_W'(1);
               end
               OP_HLT: begin
                  state_d = ST_HALT;
                  pc_d    = pc_q;
               end
               default: begin
               end
            endcase
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM, PC and instruction register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= {PC_W{1'b0}};
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Register file, flags and output port.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) regs_q[i] <= {DATA_W{1'b0}};
         {c_q, v_q, n_q, z_q} <= 4'b0000;
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         if (rf_we_s) regs_q[rd_s] <= rf_wdata_s;
         if (flag_we_s) {c_q, v_q, n_q, z_q} <= {alu_c_s, alu_v_s, alu_n_s, alu_z_s};
         if (out_we_s) out_data_q <= rs_val_s;
         out_valid_q <= out_we_s;
      end
   end

   // Memories keep their contents across reset; writes are suppressed on a reset edge.
   always_ff @(posedge clk) begin
      if (prog_valid && prog_ready && !reset) imem_q[prog_addr] <= prog_data;
      if (dmem_we_s && !reset) dmem_q[daddr_s] <= rs_val_s;
   end

   assign prog_ready = (state_q == ST_IDLE) || (state_q == ST_HALT);
   assign in_ready   = (state_q == ST_EXEC) && (opc_s == OP_IN);
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign halted     = (state_q == ST_HALT);
   assign dbg_pc     = pc_q;
   assign dbg_acc    = regs_q[0];

endmodule

// File: tb/tb_toy_cpu_mc.sv
// Directed-vector bench for toy_cpu_mc with hand-computed expectations.
module tb_toy_cpu_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_valid;
   logic [5:0]  prog_addr;
   logic [15:0] prog_data;
   logic        prog_ready;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        halted;
   logic [5:0]  dbg_pc;
   logic [7:0]  dbg_acc;

   int n_vec = 0;
   int n_err = 0;

   toy_cpu_mc #(.DATA_W(8), .PC_W(6), .DMEM_AW(4)) dut (
      .clk(clk), .reset(reset),
      .prog_valid(prog_valid), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ready(prog_ready),
      .start(start), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .halted(halted),
      .dbg_pc(dbg_pc), .dbg_acc(dbg_acc)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [5:0] addr, input logic [15:0] data);
      prog_addr  = addr;
      prog_data  = data;
      prog_valid = 1'b1;
      tick();
      prog_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_to_halt(input string tag, input int budget, output int cycles);
      cycles = 0;
      while (!halted && cycles < budget) begin
         tick();
         cycles++;
      end
      check_val(tag, 32'(halted), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_halted"}, 32'(halted), 32'd0);
      check_val({tag, "_pc"}, 32'(dbg_pc), 32'd0);
      check_val({tag, "_acc"}, 32'(dbg_acc), 32'd0);
      check_val({tag, "_outv"}, 32'(out_valid), 32'd0);
      check_val({tag, "_outd"}, 32'(out_data), 32'd0);
      check_val({tag, "_inrdy"}, 32'(in_ready), 32'd0);
      check_val({tag, "_prdy"}, 32'(prog_ready), 32'd1);
   endtask

   initial begin
      int cyc;
      int pulses;
      bit wrapped;
      logic [5:0] prev_pc;

      reset = 1'b1; prog_valid = 1'b0; prog_addr = 6'd0; prog_data = 16'h0000;
      start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      check_reset_state("rst");

      // Program 1: LDI R0,5; ADDI R0,10; SUBI R0,2; HLT -> R0=13, 8 cycles.
      load(6'd0, 16'h1005); load(6'd1, 16'h300A); load(6'd2, 16'h5002); load(6'd3, 16'hF000);
      do_start();
      for (int i = 0; i < 7; i++) tick();
      check_val("p1_not_yet", 32'(halted), 32'd0);
      tick();
      check_val("p1_halt8", 32'(halted), 32'd1);
      check_val("p1_acc", 32'(dbg_acc), 32'd13);
      check_val("p1_z", 32'(dut.z_q), 32'd0);
      check_val("p1_c", 32'(dut.c_q), 32'd1);
      check_val("p1_pc", 32'(dbg_pc), 32'd3);

      // Program 2: LDI R1,7F; ADDI R1,1; OUT R1; HLT -> signed overflow.
      load(6'd0, 16'h147F); load(6'd1, 16'h3401); load(6'd2, 16'hB100); load(6'd3, 16'hF000);
      do_start();
      pulses = 0;
      cyc = 0;
      while (!halted && cyc < 40) begin
         tick();
         cyc++;
         if (out_valid) pulses++;
      end
      check_val("p2_halt", 32'(halted), 32'd1);
      check_val("p2_pulses", 32'(pulses), 32'd1);
      check_val("p2_out", 32'(out_data), 32'h80);
      check_val("p2_v", 32'(dut.v_q), 32'd1);
      check_val("p2_n", 32'(dut.n_q), 32'd1);
      check_val("p2_c", 32'(dut.c_q), 32'd0);
      check_val("p2_acc_kept", 32'(dbg_acc), 32'd13);

      // Program 3: IN R2 stalls until in_valid.
      load(6'd0, 16'hA800); load(6'd1, 16'hF000);
      do_start();
      tick();
      for (int i = 0; i < 5; i++) begin
         check_val("in_ready_stall", 32'(in_ready), 32'd1);
         check_val("in_pc_frozen", 32'(dbg_pc), 32'd0);
         tick();
      end
      in_data = 8'h5A;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_val("in_ready_drop", 32'(in_ready), 32'd0);
      check_val("in_r2", 32'(dut.regs_q[2]), 32'h5A);
      check_val("in_pc", 32'(dbg_pc), 32'd1);
      run_to_halt("in_halt", 20, cyc);

      // Program 4: countdown loop with JZ exit.
      load(6'd0, 16'h1003); load(6'd1, 16'h5001); load(6'd2, 16'hD004);
      load(6'd3, 16'hC001); load(6'd4, 16'hF000);
      do_start();
      run_to_halt("loop_halt", 100, cyc);
      check_val("loop_cycles", 32'(cyc), 32'd20);
      check_val("loop_acc", 32'(dbg_acc), 32'd0);
      check_val("loop_z", 32'(dut.z_q), 32'd1);
      check_val("loop_pc", 32'(dbg_pc), 32'd4);

      // Seed dmem[2]=0x40, then a program that stalls on IN and gets reset.
      load(6'd0, 16'h1040); load(6'd1, 16'h9002); load(6'd2, 16'hF000);
      do_start();
      run_to_halt("seed_halt", 20, cyc);
      load(6'd0, 16'h8402); load(6'd1, 16'h3401); load(6'd2, 16'h9102);
      load(6'd3, 16'hA800); load(6'd4, 16'hB100); load(6'd5, 16'hF000);
      do_start();
      for (int i = 0; i < 10; i++) tick();
      check_val("st_in_ready", 32'(in_ready), 32'd1);
      check_val("st_pc", 32'(dbg_pc), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("mid");
      check_val("mid_r1", 32'(dut.regs_q[1]), 32'd0);
      check_val("mid_ir", 32'(dut.ir_q), 32'd0);
      check_val("mid_flags", 32'({dut.c_q, dut.v_q, dut.n_q, dut.z_q}), 32'd0);
      do_start();
      for (int i = 0; i < 10; i++) tick();
      in_data = 8'h11;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      run_to_halt("rerun_halt", 20, cyc);
      check_val("rerun_out", 32'(out_data), 32'h42);
      check_val("rerun_r1", 32'(dut.regs_q[1]), 32'h42);
      check_val("rerun_r2", 32'(dut.regs_q[2]), 32'h11);
      check_val("rerun_dmem", 32'(dut.dmem_q[2]), 32'h42);
      check_val("rerun_pc", 32'(dbg_pc), 32'd5);

      // All-NOP image: PC wraps 63->0, and prog writes while running are ignored.
      for (int i = 0; i < 64; i++) load(6'(i), 16'h0000);
      do_start();
      wrapped = 1'b0;
      prev_pc = dbg_pc;
      for (int i = 0; i < 160; i++) begin
         if (i >= 10 && i < 14) begin
            prog_addr  = 6'd5;
            prog_data  = 16'hF000;
            prog_valid = 1'b1;
         end else begin
            prog_valid = 1'b0;
         end
         tick();
         if (prev_pc == 6'd63 && dbg_pc == 6'd0) wrapped = 1'b1;
         prev_pc = dbg_pc;
      end
      prog_valid = 1'b0;
      check_val("wrap_seen", 32'(wrapped), 32'd1);
      check_val("wrap_running", 32'(halted), 32'd0);
      check_val("wrap_imem5", 32'(dut.imem_q[5]), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/toy_cpu_mc.md
Name: toy_cpu_mc

Overview:
- Parametrised multi-cycle successor of the single-cycle toy CPU top. Data width and PC/data-memory depth are generic.
- Adds three features over the single-cycle core:
  - explicit FETCH/EXEC state machine;
  - valid/ready program-load port in place of back-door memory writes;
  - handshaked input/output ports and a HALT state.
- Top-level core of the next board build; debug outputs go to LEDs and 7-seg.

Parameters:
- DATA_W, 8: register, ALU and data-memory word width (4..16).
- PC_W, 6: PC width; instruction memory has 2**PC_W words (PC_W <= 8).
- DMEM_AW, 4: data-memory address width (<= 8).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- prog_valid  in  1  program word write request.
- prog_addr  in  PC_W  instruction memory write address.
- prog_data  in  16  instruction word.
- prog_ready  out  1  high in IDLE and HALT; a write happens when prog_valid && prog_ready.
- start  in  1  begin execution at PC 0.
- in_valid  in  1  input data available.
- in_data  in  DATA_W  input value (switches).
- in_ready  out  1  high only while an IN instruction is waiting in EXEC.
- out_valid  out  1  one-cycle pulse when OUT executes.
- out_data  out  DATA_W  value written by OUT; held until the next OUT.
- halted  out  1  state == HALT.
- dbg_pc  out  PC_W  current PC.
- dbg_acc  out  DATA_W  R0 contents.

Behaviour:
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm. imm is zero-extended or truncated to DATA_W. Jump target is imm[PC_W-1:0].
- Opcodes:
  - 0 NOP; 1 LDI rd=imm.
  - 2 ADD rd+=rs; 3 ADDI rd+=imm; 4 SUB rd-=rs; 5 SUBI rd-=imm; 6 AND rd&=rs; 7 OR rd|=rs.
  - 8 LD rd=dmem[imm]; 9 ST dmem[imm]=rs.
  - A IN rd=in_data; B OUT out_data=rs.
  - C JMP; D JZ (if Z); E JC (if C); F HLT.
- Four registers R0..R3.
- Flags C,V,N,Z:
  - Updated only by opcodes 2..7.
  - ADD: C = carry out. SUB: computed as A+~B+1; C = carry out (1 = no borrow).
  - V = signed overflow; N = result MSB; Z = result==0.
  - AND/OR: C=V=0.
- State machine: IDLE, FETCH, EXEC, HALT.
  - IDLE: start -> FETCH, pc<=0.
  - FETCH: ir<=imem[pc] -> EXEC.
  - EXEC: executes ir, then -> FETCH (or HALT for HLT). Register write, flag update, dmem write and PC update all happen on the EXEC edge.
  - HALT: start -> FETCH with pc<=0; registers and flags are preserved.
- Latency: 2 cycles per instruction. IN stalls in EXEC with in_ready=1 until in_valid=1, then completes on that edge.
- PC:
  - Non-taken and non-jump: pc<=pc+1, wrapping modulo 2**PC_W (last word -> 0).
  - HLT leaves pc at the HLT address.
- Program load:
  - A write accepted while prog_ready=1 updates imem on that edge.
  - prog_valid while busy is ignored, with no write.
  - prog_valid and start in the same IDLE cycle: the write lands and execution starts. The first fetch sees the new word.
- Reset (any state, including mid-IN stall):
  - Next edge: state=IDLE, pc=0, ir=0, R0..R3=0, flags=0, out_data=0, out_valid=0, in_ready=0, halted=0.
  - imem and dmem contents are not reset.
- Simultaneous: a register rd written by an instruction is read by the next instruction with the new value (no hazards, multi-cycle).

Decomposition:
- Package toy_cpu_pkg holds:
  - opcode constants OP_NOP..OP_HLT;
  - state encoding ST_IDLE/ST_FETCH/ST_EXEC/ST_HALT;
  - instruction field bit positions.
- One natural sub-module: toy_alu_flags, a combinational DATA_W-generic ALU with op select (ADD/SUB/AND/OR) returning result and C,V,N,Z.
- Memories and register file are inferred in the top.

Test Plan:
- Load {1005,300A,5002,F000} via prog port, then start. Expected: halted after 8 cycles; dbg_acc=13; Z=0, C=1 (no borrow).
- LDI R1,0x7F; ADDI R1,1; OUT R1 with DATA_W=8. Expected: out_data=0x80, a single out_valid pulse, V=1, N=1.
- IN R2 with in_valid held low for 5 cycles. Expected: in_ready high throughout, pc frozen. Then in_valid=1 with in_data=0x5A. Expected: R2=0x5A, in_ready drops the next cycle.
- LDI R0,3; loop SUBI R0,1; JZ end; JMP loop. Expected: loop exits with R0=0 and Z=1; end holds HLT.
- Fill imem with NOP, PC_W=6. Expected: pc wraps 63->0. In the same run, prog_valid asserted while running does not alter imem.
- Assert reset during an IN stall. Expected: next edge gives IDLE, all registers and outputs 0. A restart via start re-runs the program correctly; dmem contents are unchanged.
